spike_scanner: RTL



---
 rtl/spike_scanner_pkg.sv | 18 +
 rtl/spike_scanner_if.sv | 27 ++
 rtl/spike_scanner_prio_enc.sv | 21 ++
 rtl/spike_scanner.sv | 95 +++++++++
 4 files changed

// File: rtl/spike_scanner_pkg.sv
// Shared types and sizing helpers for the tinyODIN spike scanner.
package tinyodin_spike_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_t;

  function automatic int f_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int f_nw(input int n, input int w);
    return n / w;
  endfunction

endpackage

// File: rtl/spike_scanner_if.sv
// Bitmap load handshake and FIFO write port of the spike scanner.
interface spike_scanner_if #(
  parameter int N  = 256,
  parameter int AW = 8,
  parameter int CW = 9
);
  logic          spk_valid_i;
  logic          spk_ready_o;
  logic [N-1:0]  spk_bitmap_i;
  logic          FIFO_full_i;
  logic          FIFO_w_en_o;
  logic [AW-1:0] FIFO_w_data_o;
  logic          done_o;
  logic [CW-1:0] spike_cnt_o;

  modport slave (
    input  spk_valid_i, spk_bitmap_i, FIFO_full_i,
    output spk_ready_o, FIFO_w_en_o, FIFO_w_data_o,
    output done_o, spike_cnt_o
  );

  modport master (
    output spk_valid_i, spk_bitmap_i, FIFO_full_i,
    input  spk_ready_o, FIFO_w_en_o, FIFO_w_data_o,
    input  done_o, spike_cnt_o
  );
endinterface

// File: rtl/spike_scanner_prio_enc.sv
// Lowest-set-bit encoder over one bitmap word.
module spike_prio_enc #(
  parameter int WORD_W = 16,
  parameter int IW     = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic [WORD_W-1:0] word,
  output logic              any_o,
  output logic [IW-1:0]     idx_o
);

  assign any_o = |word;

  // Descending walk so the lowest set bit is the last to win.
  always_comb begin
    idx_o = '0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (word[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/spike_scanner.sv
// Serialises a per-timestep spike bitmap into ascending neuron addresses.
module spike_scanner
  import tinyodin_spike_pkg::*;
#(
  parameter int N      = 256,
  parameter int WORD_W = 16
) (
  input logic           CLK,
  input logic           RST,
  spike_scanner_if.slave bus
);

  localparam int AW = f_aw(N);
  localparam int NW = f_nw(N, WORD_W);
  localparam int IW = f_aw(WORD_W);
  localparam int XW = f_aw(NW);
  localparam int CW = $clog2(N + 1);

  scan_state_t   state, state_nx;
  logic [N-1:0]  bitmap;
  logic [XW-1:0] w_idx;
  logic [CW-1:0] cnt;

  logic [WORD_W-1:0] cur;
  logic              any;
  logic [IW-1:0]     idx;
  logic [AW-1:0]     addr;
  logic              load, push, adv;

  assign cur  = bitmap[32'(w_idx) * WORD_W +: WORD_W];
  assign addr = AW'(32'(w_idx) * WORD_W + 32'(idx));

  spike_prio_enc #(
    .WORD_W (WORD_W),
    .IW     (IW)
  ) u_enc (
    .word  (cur),
    .any_o (any),
    .idx_o (idx)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    push     = 1'b0;
    adv      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.spk_valid_i) begin
          load     = 1'b1;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (any)                         push     = !bus.FIFO_full_i;
        else if (w_idx == XW'(NW - 1))   state_nx = DONE;
        else                             adv      = 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bitmap <= '0;
      w_idx  <= '0;
      cnt    <= '0;
    end else begin
      if (load) begin
        bitmap <= bus.spk_bitmap_i;
        w_idx  <= '0;
        cnt    <= '0;
      end
      if (push) begin
        bitmap[addr] <= 1'b0;
        cnt          <= cnt + CW'(1);
      end
      if (adv) w_idx <= w_idx + XW'(1);
    end
  end

  // Address stays presented while full so the retry targets the same neuron.
  assign bus.spk_ready_o   = (state == IDLE);
  assign bus.FIFO_w_en_o   = push;
  assign bus.FIFO_w_data_o = (state == SCAN && any) ? addr : '0;
  assign bus.done_o        = (state == DONE);
  assign bus.spike_cnt_o   = cnt;

endmodule
